an_encoder_seq: RTL and testbench

- Sequential AN (product) code encoder: multiplies a DATA_W-bit data word by the check constant A and emits the CODE_W-bit codeword.
- Sits on the transmit side of the SEC path. The receive side computes r = code mod A and maps r to a signed single-error location (+k means +2^(k-1), -k means -2^(k-1)).
- Uses an iterative shift-add datapath with valid/ready handshakes on both sides, one data bit per cycle.

---
 rtl/an_encoder_seq.sv | 159 +++++++++++++++
 tb/tb_an_encoder_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/an_encoder_seq.sv
// an_encoder_seq
//   Sequential AN (product) code encoder for the transmit side of the SEC path.
//   Multiplies a DATA_W-bit word by the odd check constant A using one
//   shift-add step per data bit (LSB first). The result is a CODE_W-bit
//   codeword, and every clean codeword is a multiple of A.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-high reset; an in-flight word is dropped
//     in_valid   input word valid
//     in_ready   encoder accepts a word (IDLE only)
//     in_data    data word to encode
//     out_valid  codeword valid (DONE), held until accepted
//     out_ready  downstream accepts codeword
//     out_code   codeword; keeps its last value after the handshake
//     busy       high in BUSY or DONE
//
//   Optional feature (macro AN_ENC_ERR_INJ_EN)
//     inj_pos    error position 1..CODE_W, 0 = none, >CODE_W treated as none
//     inj_neg    1 = subtract 2^(inj_pos-1), 0 = add it
//     Both are captured with in_data. The adjustment is applied when the
//     codeword is finished and wraps modulo 2^CODE_W.
//
//   state | meaning
//   IDLE  | waiting for an input word, in_ready high
//   BUSY  | one shift-add step per edge, DATA_W edges
//   DONE  | codeword presented, waiting for out_ready

module an_encoder_seq #(
  parameter int DATA_W = 8,
  parameter int A      = 1939,
  parameter int A_W    = 11,
  parameter int CODE_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef AN_ENC_ERR_INJ_EN
  input  logic [4:0]        inj_pos,
  input  logic              inj_neg,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [A_W-1:0]   A_VEC    = A_W'(A);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] shreg;
  logic [CODE_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] addend;
  logic [CODE_W-1:0] acc_sum;
  logic [CODE_W-1:0] acc_final;
  logic              last_step;

  assign last_step = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // The shift register moves right each step, so shreg[0] is data bit[cnt].
  assign addend  = shreg[0] ? ({{DATA_W{1'b0}}, A_VEC} << cnt) : '0;
  assign acc_sum = acc + addend;

`ifdef AN_ENC_ERR_INJ_EN
  logic [4:0]        inj_pos_q;
  logic              inj_neg_q;
  logic [CODE_W-1:0] inj_delta;

  always_comb begin
    inj_delta = '0;
    if (inj_pos_q != 5'd0 && 32'(inj_pos_q) <= 32'(CODE_W))
      inj_delta = CODE_W'(1) << (inj_pos_q - 5'd1);
  end

  assign acc_final = inj_neg_q ? (acc_sum - inj_delta) : (acc_sum + inj_delta);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_pos_q <= '0;
      inj_neg_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      inj_pos_q <= inj_pos;
      inj_neg_q <= inj_neg;
    end
  end
`else
  assign acc_final = acc_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      out_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          shreg <= shreg >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (last_step) begin
            acc      <= acc_final;
            out_code <= acc_final;
          end else begin
            acc <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_an_encoder_seq.sv
// tb_an_encoder_seq
//   Randomized and directed bench for an_encoder_seq. Expected codewords come
//   from plain multiplication d * A (plus the optional injected error, wrapped
//   to CODE_W bits).

module tb_an_encoder_seq;

  localparam int DATA_W = 8;
  localparam int A      = 1939;
  localparam int A_W    = 11;
  localparam int CODE_W = 19;
  localparam int LAT    = DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CODE_W-1:0] out_code;
  logic              busy;
  logic [4:0]        inj_pos = '0;
  logic              inj_neg = 1'b0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  an_encoder_seq #(
    .DATA_W(DATA_W), .A(A), .A_W(A_W), .CODE_W(CODE_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef AN_ENC_ERR_INJ_EN
    .inj_pos  (inj_pos),
    .inj_neg  (inj_neg),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code (out_code),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input int d, input int p, input bit n);
    longint v;
    v = longint'(d) * longint'(A);
`ifdef AN_ENC_ERR_INJ_EN
    if (p >= 1 && p <= CODE_W) begin
      if (n) v = v - (longint'(1) << (p - 1));
      else   v = v + (longint'(1) << (p - 1));
    end
`endif
    v = v & ((longint'(1) << CODE_W) - 1);
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until out_valid rises; a lat of 0 means it timed out.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !in_ready; i++) tick();
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // One full word: accept, optional mid-BUSY in_valid noise, backpressure, handshake.
  task automatic encode(input int d, input int p, input bit n, input int bp, input string tag);
    int lat;
    logic [31:0] exp;
    logic [CODE_W-1:0] held;
    exp = model(d, p, n);
    wait_idle();
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    inj_pos  = 5'(p);
    inj_neg  = n;
    tick();
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    inj_pos  = 5'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_out(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(LAT));
    chk({tag, "_code"}, 32'(out_code), exp);
    held = out_code;
    for (int i = 0; i < bp; i++) begin
      in_valid  = 1'($urandom);
      in_data   = DATA_W'($urandom);
      tick();
      if (out_code !== held || !out_valid || in_ready) begin
        chk({tag, "_hold_code"}, 32'(out_code), 32'(held));
        chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_keep_code"}, 32'(out_code), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [CODE_W-1:0] held;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_code", 32'(out_code), 32'd0);
    rst = 1'b0;
    tick();

    encode(1, 0, 0, 0, "d01");
    encode(8'h5A, 0, 0, 3, "d5a");
    encode(8'hFF, 0, 0, 0, "dff");
    encode(0, 0, 0, 1, "d00");

    // Reset mid-BUSY, asynchronously between edges.
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_code", 32'(out_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    encode(1, 0, 0, 0, "post_rst");

    // Long backpressure with in_valid pulse and stray out_ready before DONE.
    wait_idle();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stray_ordy_busy", 32'(busy), 32'd1);
    wait_out(lat);
    chk("bp_lat", 32'(lat), 32'(LAT - 1));
    held = out_code;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i == 7);
      tick();
      chk("bp_code", 32'(out_code), 32'd174510);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    in_data  = 8'd3;
    tick();
    in_data  = 8'd4;
    wait_out(lat);
    chk("b2b1_lat", 32'(lat), 32'(LAT));
    chk("b2b1_code", 32'(out_code), 32'd5817);
    chk("b2b1_rdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_idle_rdy", 32'(in_ready), 32'd1);
    wait_out(lat);
    in_valid = 1'b0;
    chk("b2b2_lat", 32'(lat), 32'(LAT + 1));
    chk("b2b2_code", 32'(out_code), 32'd7756);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef AN_ENC_ERR_INJ_EN
    encode(3, 5, 0, 0, "inj_p5");
    encode(3, 1, 1, 0, "inj_n1");
    encode(0, 1, 1, 0, "inj_wrap");
    encode(0, 19, 0, 0, "inj_top");
    encode(7, 25, 1, 0, "inj_oob");
`endif

    for (int k = 0; k < 25; k++) begin
      encode(int'($urandom_range(0, 255)), int'($urandom_range(0, 31)),
             1'($urandom), int'($urandom_range(0, 4)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
